// File: rtl/fme_satd_if.sv
// fme_satd_if: requester handshakes plus SATD mux, row-stream and result controls
interface fme_satd_if;
   logic       e1_req, e1_qsel, e2_req, e2_qsel, e3_req, e3_dual, e3_swap;
   logic       e1_gnt, e2_gnt, e3_gnt;
   logic       reqsel1, reqsel2;
   logic [1:0] satsel1, satsel2;
   logic       satdsel1, satdsel2;
   logic       row_valid1, row_valid2;
   logic       res_valid1, res_valid2;
   logic [1:0] res_tag1, res_tag2;
   modport master (
      output e1_req, e1_qsel, e2_req, e2_qsel, e3_req, e3_dual, e3_swap,
      input  e1_gnt, e2_gnt, e3_gnt, reqsel1, reqsel2, satsel1, satsel2,
             satdsel1, satdsel2, row_valid1, row_valid2,
             res_valid1, res_valid2, res_tag1, res_tag2
   );
   modport slave (
      input  e1_req, e1_qsel, e2_req, e2_qsel, e3_req, e3_dual, e3_swap,
      output e1_gnt, e2_gnt, e3_gnt, reqsel1, reqsel2, satsel1, satsel2,
             satdsel1, satdsel2, row_valid1, row_valid2,
             res_valid1, res_valid2, res_tag1, res_tag2
   );
endinterface

// File: rtl/fme_satd_scheduler.sv
// fme_satd_scheduler: arbitrates e1/e2/e3 onto two SATD units, steers the mux network and tags results
module fme_satd_scheduler #(
   parameter int ROWS     = 4,
   parameter int SATD_LAT = 3
) (
   input logic       clk,
   input logic       rst_n,
   fme_satd_if.slave bus
);
   localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
   localparam int D  = ROWS + SATD_LAT;
   localparam logic [CW-1:0] LAST = CW'(ROWS - 1);
   typedef enum logic {IDLE, BUSY} state_t;
   typedef struct packed {
      logic       v;
      logic       s;
      logic [1:0] t;
   } ent_t;
   state_t        st1, st2;
   logic [CW-1:0] cnt1, cnt2;
   logic          pri;
   logic          free1, free2, g1, g2, g3, g3d, u1, u2;
   logic          rs1_q, rs2_q, sd1_q, sd2_q;
   logic [1:0]    ss1_q, ss2_q;
   ent_t          dl1 [D];
   ent_t          dl2 [D];
   ent_t          in1, in2, o1, o2;
   logic          c1u1, c1u2, c2u1, c2u2;
   // arbitration: a pending e3 with priority reserves the units it needs, otherwise e1/e2 first and e3 fills in
   always_comb begin
      free1 = rst_n && (st1 == IDLE || cnt1 == LAST);
      free2 = rst_n && (st2 == IDLE || cnt2 == LAST);
      if (bus.e3_req && pri) begin
         g3 = bus.e3_dual ? free1 && free2 : free1;
         g1 = 1'b0;
         g2 = !bus.e3_dual && free2 && bus.e2_req;
      end else begin
         g1 = free1 && bus.e1_req;
         g2 = free2 && bus.e2_req;
         g3 = bus.e3_req && free1 && !g1 && (!bus.e3_dual || (free2 && !g2));
      end
      g3d = g3 && bus.e3_dual;
      u1  = g1 || g3;
      u2  = g2 || g3d;
   end
   // delay-line entries at grant; swap only ever marks a dual job so channels cannot collide
   always_comb begin
      in1  = '{v: u1, s: g3d && bus.e3_swap, t: g3 ? 2'b11 : 2'b01};
      in2  = '{v: u2, s: g3d && bus.e3_swap, t: g3d ? 2'b11 : 2'b10};
      o1   = dl1[D-1];
      o2   = dl2[D-1];
      c1u1 = o1.v && !o1.s;
      c1u2 = o2.v && o2.s;
      c2u2 = o2.v && !o2.s;
      c2u1 = o1.v && o1.s;
   end
   assign bus.e1_gnt     = g1;
   assign bus.e2_gnt     = g2;
   assign bus.e3_gnt     = g3;
   assign bus.reqsel1    = g1 ? bus.e1_qsel : rs1_q;
   assign bus.reqsel2    = g2 ? bus.e2_qsel : rs2_q;
   assign bus.satsel1    = g3 ? 2'b01 : g1 ? 2'b00 : ss1_q;
   assign bus.satsel2    = g3d ? 2'b10 : g2 ? 2'b00 : ss2_q;
   assign bus.row_valid1 = st1 == BUSY;
   assign bus.row_valid2 = st2 == BUSY;
   assign bus.res_valid1 = c1u1 || c1u2;
   assign bus.res_valid2 = c2u2 || c2u1;
   assign bus.res_tag1   = c1u1 ? o1.t : c1u2 ? o2.t : 2'b00;
   assign bus.res_tag2   = c2u2 ? o2.t : c2u1 ? o1.t : 2'b00;
   assign bus.satdsel1   = c1u1 ? 1'b0 : c1u2 ? 1'b1 : sd1_q;
   assign bus.satdsel2   = c2u2 ? 1'b1 : c2u1 ? 1'b0 : sd2_q;
   // unit FSMs, e3 priority and the latched mux selects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st1   <= IDLE;
         st2   <= IDLE;
         cnt1  <= '0;
         cnt2  <= '0;
         pri   <= 1'b0;
         rs1_q <= 1'b0;
         rs2_q <= 1'b0;
         ss1_q <= 2'b00;
         ss2_q <= 2'b00;
         sd1_q <= 1'b0;
         sd2_q <= 1'b1;
      end else begin
         st1   <= u1 ? BUSY : free1 ? IDLE : st1;
         st2   <= u2 ? BUSY : free2 ? IDLE : st2;
         cnt1  <= (u1 || free1) ? '0 : cnt1 + CW'(1);
         cnt2  <= (u2 || free2) ? '0 : cnt2 + CW'(1);
         pri   <= g3 ? 1'b0 : ((g1 || g2) && bus.e3_req) ? 1'b1 : pri;
         rs1_q <= bus.reqsel1;
         rs2_q <= bus.reqsel2;
         ss1_q <= bus.satsel1;
         ss2_q <= bus.satsel2;
         sd1_q <= bus.satdsel1;
         sd2_q <= bus.satdsel2;
      end
   end
   // result delay lines: a job granted at t surfaces at t+ROWS+SATD_LAT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) begin
            dl1[i] <= '0;
            dl2[i] <= '0;
         end
      end else begin
         dl1[0] <= in1;
         dl2[0] <= in2;
         for (int i = 1; i < D; i++) begin
            dl1[i] <= dl1[i-1];
            dl2[i] <= dl2[i-1];
         end
      end
   end
endmodule

// File: tb/tb_fme_satd_scheduler.sv
// tb_fme_satd_scheduler: directed scenarios plus a randomized run against an ownership-based model
module tb_fme_satd_scheduler;
   localparam int ROWS = 4;
   localparam int LAT  = 3;
   localparam int D    = ROWS + LAT;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int tests = 0;
   int fails = 0;
   fme_satd_if bus();
   fme_satd_scheduler #(.ROWS(ROWS), .SATD_LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   task automatic clear_inputs();
      bus.e1_req = 0; bus.e1_qsel = 0; bus.e2_req = 0; bus.e2_qsel = 0;
      bus.e3_req = 0; bus.e3_dual = 0; bus.e3_swap = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      bus.e1_req = 1; bus.e2_req = 1; bus.e3_req = 1;
      rst_n = 1'b0;
      #1;
      tests++; if ({bus.e1_gnt, bus.e2_gnt, bus.e3_gnt} !== 3'b000) begin fails++; $display("FAIL rst_gnt got %b exp 000", {bus.e1_gnt, bus.e2_gnt, bus.e3_gnt}); end
      tests++; if ({bus.row_valid1, bus.row_valid2, bus.res_valid1, bus.res_valid2} !== 4'b0000) begin fails++; $display("FAIL rst_valid got %b exp 0000", {bus.row_valid1, bus.row_valid2, bus.res_valid1, bus.res_valid2}); end
      tests++; if ({bus.reqsel1, bus.reqsel2, bus.satsel1, bus.satsel2} !== 6'b0) begin fails++; $display("FAIL rst_sel got %b exp 000000", {bus.reqsel1, bus.reqsel2, bus.satsel1, bus.satsel2}); end
      tests++; if ({bus.satdsel1, bus.satdsel2} !== 2'b01) begin fails++; $display("FAIL rst_satdsel got %b exp 01", {bus.satdsel1, bus.satdsel2}); end
      tests++; if ({bus.res_tag1, bus.res_tag2} !== 4'b0000) begin fails++; $display("FAIL rst_tag got %b exp 0000", {bus.res_tag1, bus.res_tag2}); end
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_e1_single();
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         bus.e1_req = (c == 1); bus.e1_qsel = 1;
         #1;
         tests++; if (bus.e1_gnt !== (c == 1)) begin fails++; $display("FAIL e1_gnt c=%0d got %b exp %b", c, bus.e1_gnt, c == 1); end
         tests++; if (bus.row_valid1 !== (c >= 2 && c <= 5)) begin fails++; $display("FAIL e1_rowv c=%0d got %b", c, bus.row_valid1); end
         if (c <= 5) begin
            tests++; if (bus.reqsel1 !== 1'b1 || bus.satsel1 !== 2'b00) begin fails++; $display("FAIL e1_sel c=%0d got %b/%b exp 1/00", c, bus.reqsel1, bus.satsel1); end
         end
         tests++; if (bus.res_valid1 !== (c == 8) || bus.res_valid2 !== 1'b0) begin fails++; $display("FAIL e1_resv c=%0d got %b%b", c, bus.res_valid1, bus.res_valid2); end
         if (c == 8) begin
            tests++; if (bus.res_tag1 !== 2'b01 || bus.satdsel1 !== 1'b0) begin fails++; $display("FAIL e1_res c=%0d got tag %b sel %b exp 01 0", c, bus.res_tag1, bus.satdsel1); end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit gx, rx;
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         bus.e1_req = 1; bus.e2_req = 1;
         #1;
         gx = ((c - 1) % ROWS) == 0;
         rx = c >= 1 + D && ((c - 1 - D) % ROWS) == 0;
         tests++; if (bus.e1_gnt !== gx || bus.e2_gnt !== gx) begin fails++; $display("FAIL b2b_gnt c=%0d got %b%b exp %b", c, bus.e1_gnt, bus.e2_gnt, gx); end
         tests++; if (bus.row_valid1 !== (c >= 2) || bus.row_valid2 !== (c >= 2)) begin fails++; $display("FAIL b2b_rowv c=%0d got %b%b", c, bus.row_valid1, bus.row_valid2); end
         tests++; if (bus.res_valid1 !== rx || bus.res_valid2 !== rx) begin fails++; $display("FAIL b2b_resv c=%0d got %b%b exp %b", c, bus.res_valid1, bus.res_valid2, rx); end
         if (rx) begin
            tests++; if (bus.res_tag1 !== 2'b01 || bus.res_tag2 !== 2'b10) begin fails++; $display("FAIL b2b_tag c=%0d got %b %b exp 01 10", c, bus.res_tag1, bus.res_tag2); end
         end
      end
      clear_inputs();
   endtask

   task automatic test_e3_reserve();
      do_reset();
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         bus.e1_req = (c == 1);
         bus.e3_req = (c >= 2 && c <= 5); bus.e3_dual = 1;
         #1;
         tests++; if ({bus.e1_gnt, bus.e2_gnt, bus.e3_gnt} !== {c == 1, 1'b0, c == 5}) begin fails++; $display("FAIL rsv_gnt c=%0d got %b", c, {bus.e1_gnt, bus.e2_gnt, bus.e3_gnt}); end
         tests++; if (bus.row_valid2 !== (c >= 6 && c <= 9)) begin fails++; $display("FAIL rsv_rowv2 c=%0d got %b", c, bus.row_valid2); end
         if (c >= 5 && c <= 9) begin
            tests++; if (bus.satsel1 !== 2'b01 || bus.satsel2 !== 2'b10) begin fails++; $display("FAIL rsv_satsel c=%0d got %b %b exp 01 10", c, bus.satsel1, bus.satsel2); end
         end
         tests++; if (bus.res_valid1 !== (c == 8 || c == 12) || bus.res_valid2 !== (c == 12)) begin fails++; $display("FAIL rsv_resv c=%0d got %b%b", c, bus.res_valid1, bus.res_valid2); end
         if (c == 12) begin
            tests++; if (bus.res_tag1 !== 2'b11 || bus.res_tag2 !== 2'b11 || bus.satdsel1 !== 1'b0 || bus.satdsel2 !== 1'b1) begin fails++; $display("FAIL rsv_res got %b %b sel %b%b exp 11 11 01", bus.res_tag1, bus.res_tag2, bus.satdsel1, bus.satdsel2); end
         end
      end
      clear_inputs();
   endtask

   task automatic test_e3_swap();
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         bus.e3_req = (c == 1); bus.e3_dual = 1; bus.e3_swap = 1;
         #1;
         tests++; if (bus.e3_gnt !== (c == 1)) begin fails++; $display("FAIL swp_gnt c=%0d got %b", c, bus.e3_gnt); end
         tests++; if (bus.res_valid1 !== (c == 8) || bus.res_valid2 !== (c == 8)) begin fails++; $display("FAIL swp_resv c=%0d got %b%b", c, bus.res_valid1, bus.res_valid2); end
         if (c >= 8) begin
            tests++; if (bus.satdsel1 !== 1'b1 || bus.satdsel2 !== 1'b0) begin fails++; $display("FAIL swp_sel c=%0d got %b%b exp 10", c, bus.satdsel1, bus.satdsel2); end
         end
         if (c == 8) begin
            tests++; if (bus.res_tag1 !== 2'b11 || bus.res_tag2 !== 2'b11) begin fails++; $display("FAIL swp_tag got %b %b exp 11 11", bus.res_tag1, bus.res_tag2); end
         end
      end
      clear_inputs();
   endtask

   task automatic test_e3_single_e2();
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         bus.e3_req = (c == 1); bus.e3_dual = 0; bus.e2_req = (c == 1);
         #1;
         tests++; if ({bus.e1_gnt, bus.e2_gnt, bus.e3_gnt} !== {1'b0, c == 1, c == 1}) begin fails++; $display("FAIL sgl_gnt c=%0d got %b", c, {bus.e1_gnt, bus.e2_gnt, bus.e3_gnt}); end
         if (c == 1) begin
            tests++; if (bus.satsel1 !== 2'b01 || bus.satsel2 !== 2'b00) begin fails++; $display("FAIL sgl_satsel got %b %b exp 01 00", bus.satsel1, bus.satsel2); end
         end
         if (c == 8) begin
            tests++; if ({bus.res_valid1, bus.res_valid2, bus.res_tag1, bus.res_tag2, bus.satdsel1, bus.satdsel2} !== 8'b11_11_10_01) begin fails++; $display("FAIL sgl_res got %b exp 11111001", {bus.res_valid1, bus.res_valid2, bus.res_tag1, bus.res_tag2, bus.satdsel1, bus.satdsel2}); end
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_midjob();
      do_reset();
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         if (c == 4) rst_n = 1'b1;
         bus.e1_req = (c == 1 || c == 5); bus.e1_qsel = (c == 1);
         #1;
         if (c == 3) begin
            rst_n = 1'b0;
            #1;
            tests++; if ({bus.row_valid1, bus.reqsel1, bus.satsel1, bus.satdsel1, bus.satdsel2} !== 6'b000001) begin fails++; $display("FAIL mid_rst got %b exp 000001", {bus.row_valid1, bus.reqsel1, bus.satsel1, bus.satdsel1, bus.satdsel2}); end
         end else if (c >= 4) begin
            tests++; if (bus.e1_gnt !== (c == 5)) begin fails++; $display("FAIL mid_gnt c=%0d got %b", c, bus.e1_gnt); end
            tests++; if (bus.row_valid1 !== (c >= 6 && c <= 9)) begin fails++; $display("FAIL mid_rowv c=%0d got %b", c, bus.row_valid1); end
            tests++; if (bus.res_valid1 !== (c == 12) || bus.res_valid2 !== 1'b0) begin fails++; $display("FAIL mid_resv c=%0d got %b%b", c, bus.res_valid1, bus.res_valid2); end
         end
      end
      clear_inputs();
   endtask

   // model: per-cycle ownership of each unit (0 none, 1 e1, 2 e2, 3 e3) decided from the arbitration rules
   task automatic test_random(input int n);
      int lastg1, lastg2, own1, own2, slot, due;
      bit pri, f1, f2, sw, rs1, rs2, hd1, hd2, drop1, drop2, drop3;
      bit [1:0] ss1, ss2;
      bit ev1 [32], ev2 [32], es1 [32], es2 [32];
      bit [1:0] et1 [32], et2 [32];
      do_reset();
      lastg1 = -100; lastg2 = -100; pri = 0; rs1 = 0; rs2 = 0; ss1 = 0; ss2 = 0; hd1 = 0; hd2 = 1;
      drop1 = 0; drop2 = 0; drop3 = 0;
      for (int i = 0; i < 32; i++) begin ev1[i] = 0; ev2[i] = 0; es1[i] = 0; es2[i] = 0; et1[i] = 0; et2[i] = 0; end
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (drop1) bus.e1_req = 0;
         if (drop2) bus.e2_req = 0;
         if (drop3) bus.e3_req = 0;
         if (!bus.e1_req && $urandom_range(0, 2) == 0) begin bus.e1_req = 1; bus.e1_qsel = 1'($urandom_range(0, 1)); end
         if (!bus.e2_req && $urandom_range(0, 2) == 0) begin bus.e2_req = 1; bus.e2_qsel = 1'($urandom_range(0, 1)); end
         if (!bus.e3_req && $urandom_range(0, 3) == 0) begin bus.e3_req = 1; bus.e3_dual = 1'($urandom_range(0, 1)); bus.e3_swap = 1'($urandom_range(0, 1)); end
         #1;
         f1 = c >= lastg1 + ROWS;
         f2 = c >= lastg2 + ROWS;
         own1 = 0; own2 = 0;
         if (bus.e3_req && pri) begin
            if (bus.e3_dual) begin
               if (f1 && f2) begin own1 = 3; own2 = 3; end
            end else begin
               if (f1) own1 = 3;
               if (f2 && bus.e2_req) own2 = 2;
            end
         end else begin
            if (f1 && bus.e1_req) own1 = 1;
            if (f2 && bus.e2_req) own2 = 2;
            if (bus.e3_req && bus.e3_dual && own1 == 0 && own2 == 0 && f1 && f2) begin own1 = 3; own2 = 3; end
            else if (bus.e3_req && !bus.e3_dual && own1 == 0 && f1) own1 = 3;
         end
         tests++; if ({bus.e1_gnt, bus.e2_gnt, bus.e3_gnt} !== {own1 == 1, own2 == 2, own1 == 3}) begin fails++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, {bus.e1_gnt, bus.e2_gnt, bus.e3_gnt}, {own1 == 1, own2 == 2, own1 == 3}); end
         tests++; if (bus.row_valid1 !== (c > lastg1 && c <= lastg1 + ROWS) || bus.row_valid2 !== (c > lastg2 && c <= lastg2 + ROWS)) begin fails++; $display("FAIL rnd_rowv c=%0d got %b%b", c, bus.row_valid1, bus.row_valid2); end
         if (own1 != 0) lastg1 = c;
         if (own2 != 0) lastg2 = c;
         if (own1 == 1) rs1 = bus.e1_qsel;
         if (own2 == 2) rs2 = bus.e2_qsel;
         ss1 = own1 == 3 ? 2'b01 : own1 == 1 ? 2'b00 : ss1;
         ss2 = own2 == 3 ? 2'b10 : own2 == 2 ? 2'b00 : ss2;
         tests++; if ({bus.reqsel1, bus.reqsel2, bus.satsel1, bus.satsel2} !== {rs1, rs2, ss1, ss2}) begin fails++; $display("FAIL rnd_sel c=%0d got %b exp %b", c, {bus.reqsel1, bus.reqsel2, bus.satsel1, bus.satsel2}, {rs1, rs2, ss1, ss2}); end
         slot = c % 32;
         if (ev1[slot]) hd1 = es1[slot];
         if (ev2[slot]) hd2 = es2[slot];
         tests++; if ({bus.res_valid1, bus.res_valid2} !== {ev1[slot], ev2[slot]}) begin fails++; $display("FAIL rnd_resv c=%0d got %b%b exp %b%b", c, bus.res_valid1, bus.res_valid2, ev1[slot], ev2[slot]); end
         tests++; if ({bus.res_tag1, bus.res_tag2} !== {ev1[slot] ? et1[slot] : 2'b00, ev2[slot] ? et2[slot] : 2'b00}) begin fails++; $display("FAIL rnd_tag c=%0d got %b %b", c, bus.res_tag1, bus.res_tag2); end
         tests++; if ({bus.satdsel1, bus.satdsel2} !== {hd1, hd2}) begin fails++; $display("FAIL rnd_satdsel c=%0d got %b%b exp %b%b", c, bus.satdsel1, bus.satdsel2, hd1, hd2); end
         ev1[slot] = 0; ev2[slot] = 0;
         due = (c + D) % 32;
         sw = own2 == 3 && bus.e3_swap;
         if (own1 != 0) begin
            if (sw) begin ev2[due] = 1; et2[due] = 2'b11; es2[due] = 0; end
            else begin ev1[due] = 1; et1[due] = 2'(own1); es1[due] = 0; end
         end
         if (own2 != 0) begin
            if (sw) begin ev1[due] = 1; et1[due] = 2'b11; es1[due] = 1; end
            else begin ev2[due] = 1; et2[due] = 2'(own2); es2[due] = 1; end
         end
         if (own1 == 3) pri = 0;
         else if ((own1 == 1 || own2 == 2) && bus.e3_req) pri = 1;
         drop1 = own1 == 1; drop2 = own2 == 2; drop3 = own1 == 3;
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_e1_single();
      test_back_to_back();
      test_e3_reserve();
      test_e3_swap();
      test_e3_single_e2();
      test_reset_midjob();
      test_random(800);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
